// File: rtl/bist_pkg.sv
// Shared types and per-element constant tables for the March C- BIST sequencer.
package bist_pkg;

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } march_elem_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

    // Bit i of each table describes element Mi.
    localparam logic [5:0] ELEM_UP     = 6'b100111;
    localparam logic [5:0] ELEM_HAS_RD = 6'b111110;
    localparam logic [5:0] ELEM_HAS_WR = 6'b011111;
    localparam logic [5:0] ELEM_RD_ONE = 6'b010100;
    localparam logic [5:0] ELEM_WR_ONE = 6'b001010;

    function automatic logic elem_up(input march_elem_t e);
        return ELEM_UP[e];
    endfunction

    function automatic logic elem_has_rd(input march_elem_t e);
        return ELEM_HAS_RD[e];
    endfunction

    function automatic logic elem_has_wr(input march_elem_t e);
        return ELEM_HAS_WR[e];
    endfunction

    function automatic logic elem_rd_one(input march_elem_t e);
        return ELEM_RD_ONE[e];
    endfunction

    function automatic logic elem_wr_one(input march_elem_t e);
        return ELEM_WR_ONE[e];
    endfunction

    function automatic march_elem_t next_elem(input march_elem_t e);
        return march_elem_t'(e + 3'd1);
    endfunction

endpackage

// File: rtl/bist_addr_counter.sv
// Loadable up/down address counter; the terminal-count flag follows the current direction.
module bist_addr_counter #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_en,
    input  logic              i_up,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_tc
);

    logic [ADDR_W-1:0] r_addr;

    // Address register: load beats count so element changes need no idle cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_val;
        end else if (i_en) begin
            if (i_up) begin
                r_addr <= r_addr + ADDR_W'(1);
            end else begin
                r_addr <= r_addr - ADDR_W'(1);
            end
        end
    end

    assign o_addr = r_addr;
    assign o_tc   = i_up ? (&r_addr) : (~|r_addr);

endmodule

// File: rtl/bist_march_controller.sv
// March C- sequencer: issues SRAM commands, presents expected read data and
// accumulates fail status from the external comparator's eq result.
module bist_march_controller
    import bist_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic [DATA_W-1:0] data_t,
    output logic              cmp_valid,
    input  logic              eq,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [CNT_W-1:0]  fail_count
);

    // The state/element/op/counter registers describe the command currently on the bus.
    ctrl_state_t       r_state;
    march_elem_t       r_elem;
    op_t               r_op;
    logic              r_drain2;
    logic              r_ram_cs;
    logic              r_ram_we;
    logic [DATA_W-1:0] r_ram_din;
    logic [DATA_W-1:0] r_data_t;
    logic              r_cmp_valid;
    logic [ADDR_W-1:0] r_cmp_addr;
    logic              r_busy;
    logic              r_done;
    logic              r_fail;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [CNT_W-1:0]  r_fail_count;

    ctrl_state_t       w_state_nxt;
    march_elem_t       w_elem_nxt;
    op_t               w_op_nxt;
    logic              w_drain_nxt;
    logic              w_issue;
    logic              w_clear;
    logic              w_cnt_load;
    logic [ADDR_W-1:0] w_cnt_load_val;
    logic              w_cnt_en;
    logic              w_cnt_up;
    logic [ADDR_W-1:0] w_cnt_addr;
    logic              w_cnt_tc;
    logic              w_is_read;
    logic              w_miscompare;

    bist_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_addr_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_en       (w_cnt_en),
        .i_up       (w_cnt_up),
        .o_addr     (w_cnt_addr),
        .o_tc       (w_cnt_tc)
    );

    assign w_is_read    = (r_state == RUN) && (r_op == OP_RD);
    assign w_miscompare = r_cmp_valid && !eq;

    // Next-command and next-state decode
    always_comb begin
        w_state_nxt    = r_state;
        w_elem_nxt     = r_elem;
        w_op_nxt       = r_op;
        w_drain_nxt    = 1'b0;
        w_issue        = 1'b0;
        w_clear        = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_en       = 1'b0;
        w_cnt_up       = elem_up(r_elem);
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt    = RUN;
                    w_elem_nxt     = M0;
                    w_op_nxt       = OP_WR;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = '0;
                    w_issue        = 1'b1;
                    w_clear        = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            RUN: begin
                if ((r_op == OP_RD) && elem_has_wr(r_elem)) begin
                    w_op_nxt = OP_WR;
                    w_issue  = 1'b1;
                end else if (!w_cnt_tc) begin
                    w_cnt_en = 1'b1;
                    w_op_nxt = elem_has_rd(r_elem) ? OP_RD : OP_WR;
                    w_issue  = 1'b1;
                end else if (r_elem == M5) begin
                    // Park the address at zero while the last read is compared
                    w_state_nxt    = DRAIN;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = '0;
                end else begin
                    w_elem_nxt     = next_elem(r_elem);
                    w_op_nxt       = elem_has_rd(w_elem_nxt) ? OP_RD : OP_WR;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = elem_up(w_elem_nxt) ? {ADDR_W{1'b0}} : {ADDR_W{1'b1}};
                    w_issue        = 1'b1;
                end
            end
            DRAIN: begin
                // First cycle carries the final compare, second lets status settle
                if (r_drain2) begin
                    w_state_nxt = DONE;
                end else begin
                    w_drain_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Sequencer state and registered SRAM/comparator-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_elem      <= M0;
            r_op        <= OP_RD;
            r_drain2    <= 1'b0;
            r_ram_cs    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_din   <= '0;
            r_data_t    <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_addr  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_elem      <= w_elem_nxt;
            r_op        <= w_op_nxt;
            r_drain2    <= w_drain_nxt;
            r_ram_cs    <= w_issue;
            r_ram_we    <= w_issue && (w_op_nxt == OP_WR);
            r_ram_din   <= (w_issue && (w_op_nxt == OP_WR) && elem_wr_one(w_elem_nxt))
                           ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            r_cmp_valid <= w_is_read;
            r_data_t    <= (w_is_read && elem_rd_one(r_elem)) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            r_cmp_addr  <= w_cnt_addr;
            r_busy      <= (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
            r_done      <= (w_state_nxt == DONE);
        end
    end

    // Pass/fail accumulation; a restart clears the previous result
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_fail       <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_count <= '0;
        end else if (w_miscompare) begin
            r_fail <= 1'b1;
            if (!r_fail) begin
                r_fail_addr <= r_cmp_addr;
            end
            if (r_fail_count != {CNT_W{1'b1}}) begin
                r_fail_count <= r_fail_count + CNT_W'(1);
            end
        end
    end

    assign ram_cs     = r_ram_cs;
    assign ram_we     = r_ram_we;
    assign ram_addr   = w_cnt_addr;
    assign ram_din    = r_ram_din;
    assign data_t     = r_data_t;
    assign cmp_valid  = r_cmp_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fail       = r_fail;
    assign fail_addr  = r_fail_addr;
    assign fail_count = r_fail_count;

endmodule

// File: tb/tb_bist_march_controller.sv
// Directed bench: SRAM model with injectable faults plus inline comparator.
module tb_bist_march_controller;

    localparam int TR_LEN = 700;

    logic       clk;
    logic       rst;
    logic       start;
    logic       ram_cs;
    logic       ram_we;
    logic [5:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] data_t;
    logic       cmp_valid;
    logic       eq;
    logic       busy;
    logic       done;
    logic       fail;
    logic [5:0] fail_addr;
    logic [7:0] fail_count;

    bist_march_controller #(.ADDR_W(6), .DATA_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ram_cs     (ram_cs),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .data_t     (data_t),
        .cmp_valid  (cmp_valid),
        .eq         (eq),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_count (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: 0 = fault-free, 1 = bit0 stuck-at-1 at 0x15, 2 = reads return ~data
    int         fault_mode;
    logic [7:0] mem [0:63];
    logic [7:0] ramout;

    function automatic logic [7:0] rd_model(input logic [5:0] a);
        logic [7:0] d;
        d = mem[a];
        if (fault_mode == 1 && a == 6'h15) d = d | 8'h01;
        if (fault_mode == 2) d = ~d;
        return d;
    endfunction

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ramout <= rd_model(ram_addr);
        end
    end

    assign eq = (ramout == data_t);

    logic [41:0] all_outs;
    assign all_outs = {ram_cs, ram_we, ram_addr, ram_din, data_t, cmp_valid,
                       busy, done, fail, fail_addr, fail_count};

    int checks = 0;
    int errors = 0;
    int n_wr, n_rd, n_cv, n_mis, cyc;
    logic       fail_t0, done_t0;
    logic [7:0] cnt_t0;

    logic       tr_cs [0:TR_LEN-1];
    logic       tr_we [0:TR_LEN-1];
    logic [5:0] tr_addr [0:TR_LEN-1];
    logic [7:0] tr_din [0:TR_LEN-1];
    logic       tr_cv [0:TR_LEN-1];
    logic [7:0] tr_dt [0:TR_LEN-1];
    logic       tr_busy [0:TR_LEN-1];
    logic       tr_done [0:TR_LEN-1];

    typedef struct {
        int         t;
        logic       cs;
        logic       we;
        logic [5:0] addr;
        logic       dchk;
        logic [7:0] din;
        logic       cv;
        logic [7:0] dt;
        logic       busy;
        logic       done;
    } vec_t;
    vec_t vq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sample(input int t);
        if (t < TR_LEN) begin
            tr_cs[t] = ram_cs;   tr_we[t] = ram_we;   tr_addr[t] = ram_addr;
            tr_din[t] = ram_din; tr_cv[t] = cmp_valid; tr_dt[t] = data_t;
            tr_busy[t] = busy;   tr_done[t] = done;
        end
        if (ram_cs && ram_we)  n_wr++;
        if (ram_cs && !ram_we) n_rd++;
        if (cmp_valid) n_cv++;
        if (cmp_valid && !eq) n_mis++;
    endtask

    // t counts edges after the edge that sampled start
    task automatic run_test(input int mode, input bit pulse, output int cycles);
        int t;
        fault_mode = mode;
        n_wr = 0; n_rd = 0; n_cv = 0; n_mis = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        sample(t);
        fail_t0 = fail; done_t0 = done; cnt_t0 = fail_count;
        while (!done && t < 2000) begin
            start = (pulse && t >= 10 && t < 600 && (t % 50) == 10) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            t++;
            sample(t);
        end
        start = 1'b0;
        cycles = t;
        check("done within budget", done, 1);
    endtask

    task automatic check_table();
        vec_t v;
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            check($sformatf("t%0d cs", v.t), tr_cs[v.t], v.cs);
            if (v.cs) begin
                check($sformatf("t%0d we", v.t), tr_we[v.t], v.we);
                check($sformatf("t%0d addr", v.t), tr_addr[v.t], v.addr);
            end
            if (v.dchk) check($sformatf("t%0d din", v.t), tr_din[v.t], v.din);
            check($sformatf("t%0d cmp_valid", v.t), tr_cv[v.t], v.cv);
            check($sformatf("t%0d data_t", v.t), tr_dt[v.t], v.dt);
            check($sformatf("t%0d busy", v.t), tr_busy[v.t], v.busy);
            check($sformatf("t%0d done", v.t), tr_done[v.t], v.done);
        end
    endtask

    initial begin
        //            t   cs    we    addr   dchk  din    cv    dt     busy  done
        vq.push_back('{0,   1'b1, 1'b1, 6'd0,  1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0});
        vq.push_back('{63,  1'b1, 1'b1, 6'd63, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0});
        vq.push_back('{64,  1'b1, 1'b0, 6'd0,  1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0});
        vq.push_back('{65,  1'b1, 1'b1, 6'd0,  1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0});
        vq.push_back('{66,  1'b1, 1'b0, 6'd1,  1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0});
        vq.push_back('{191, 1'b1, 1'b1, 6'd63, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0});
        vq.push_back('{192, 1'b1, 1'b0, 6'd0,  1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0});
        vq.push_back('{193, 1'b1, 1'b1, 6'd0,  1'b1, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0});
        vq.push_back('{320, 1'b1, 1'b0, 6'd63, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0});
        vq.push_back('{321, 1'b1, 1'b1, 6'd63, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0});
        vq.push_back('{448, 1'b1, 1'b0, 6'd63, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0});
        vq.push_back('{449, 1'b1, 1'b1, 6'd63, 1'b1, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0});
        vq.push_back('{575, 1'b1, 1'b1, 6'd0,  1'b1, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0});
        vq.push_back('{576, 1'b1, 1'b0, 6'd0,  1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0});
        vq.push_back('{577, 1'b1, 1'b0, 6'd1,  1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0});
        vq.push_back('{639, 1'b1, 1'b0, 6'd63, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0});
        vq.push_back('{640, 1'b0, 1'b0, 6'd0,  1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0});
        vq.push_back('{641, 1'b0, 1'b0, 6'd0,  1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0});
        vq.push_back('{642, 1'b0, 1'b0, 6'd0,  1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1});

        rst = 1'b1; start = 1'b0; fault_mode = 0; ramout = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", all_outs, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle ram_cs", ram_cs, 0);
        check("idle busy", busy, 0);

        // Fault-free run
        run_test(0, 1'b0, cyc);
        check("clean done cycle", cyc, 642);
        check("clean fail", fail, 0);
        check("clean fail_count", fail_count, 0);
        check("clean writes", n_wr, 320);
        check("clean reads", n_rd, 320);
        check("clean cmp_valid", n_cv, 320);
        check("clean miscompares", n_mis, 0);
        check_table();
        repeat (5) @(posedge clk);
        #1;
        check("done held", done, 1);
        check("done ram_cs", ram_cs, 0);

        // Stuck-at-1 bit 0 at 0x15, restarted from DONE
        run_test(1, 1'b0, cyc);
        check("restart clears done", done_t0, 0);
        check("sa1 done cycle", cyc, 642);
        check("sa1 fail", fail, 1);
        check("sa1 fail_addr", fail_addr, 6'h15);
        check("sa1 fail_count", fail_count, 3);
        check("sa1 miscompares", n_mis, 3);

        // Inverting memory: every read miscompares
        run_test(2, 1'b0, cyc);
        check("inv restart clears fail", fail_t0, 0);
        check("inv restart clears count", cnt_t0, 0);
        check("inv miscompares", n_mis, 320);
        check("inv fail", fail, 1);
        check("inv fail_count saturates", fail_count, 255);
        check("inv fail_addr", fail_addr, 6'h00);

        // Clean run with start pulses while busy
        run_test(0, 1'b1, cyc);
        check("pulse restart clears fail", fail_t0, 0);
        check("pulse done cycle", cyc, 642);
        check("pulse fail", fail, 0);
        check("pulse writes", n_wr, 320);
        check("pulse reads", n_rd, 320);
        check_table();

        // Abort mid-M2 with rst and start together
        fault_mode = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (250) @(posedge clk);
        #1;
        check("mid-M2 busy", busy, 1);
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        check("abort outputs", all_outs, 0);
        rst = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort stays idle", busy, 0);
        check("abort no cs", ram_cs, 0);
        run_test(0, 1'b0, cyc);
        check("post-abort done cycle", cyc, 642);
        check("post-abort fail", fail, 0);
        check("post-abort writes", n_wr, 320);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
